// File: rtl/traffic_pkg.sv
// Shared definitions for junction and lamp controllers: state codes,
// one-hot lamp codes and a helper that maps a state to its lamp pair.
package traffic_pkg;

    // Junction controller states; code 7 is unused and recovers to AR_M.
    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        AR_S   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        AR_M   = 3'd5,
        EMERG  = 3'd6
    } tj_state_e;

    // One-hot lamp codes, ordered {red, green, yellow}.
    localparam logic [0:2] RED    = 3'b100;
    localparam logic [0:2] GREEN  = 3'b010;
    localparam logic [0:2] YELLOW = 3'b001;

    typedef struct packed {
        logic [0:2] main_lamp;
        logic [0:2] side_lamp;
    } lamp_pair_t;

    // Moore lamp decode; anything not explicitly a go/caution state is all-red.
    function automatic lamp_pair_t decode_lamps(input tj_state_e st);
        lamp_pair_t lp;
        lp.main_lamp = RED;
        lp.side_lamp = RED;
        case (st)
            MAIN_G: begin
                lp.main_lamp = GREEN;
                lp.side_lamp = RED;
            end
            MAIN_Y: begin
                lp.main_lamp = YELLOW;
                lp.side_lamp = RED;
            end
            SIDE_G: begin
                lp.main_lamp = RED;
                lp.side_lamp = GREEN;
            end
            SIDE_Y: begin
                lp.main_lamp = RED;
                lp.side_lamp = YELLOW;
            end
            default: begin
                lp.main_lamp = RED;
                lp.side_lamp = RED;
            end
        endcase
        return lp;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state dwell counter: cleared when the controller changes state,
// otherwise counts up and sticks at its maximum value.
module phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic [TW-1:0] count
);

    localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);
    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

    // Dwell counter: zero on the first cycle of each state, saturating increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else if (clr) begin
            count <= CNT_ZERO;
        end else if (count != CNT_MAX) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Two-road junction controller with side-road and pedestrian demand,
// walk lamp and emergency override. Lamps are registered from the
// next-state decode so they always match the current state register.
module traffic_junction_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned T_MIN_G  = 8,
    parameter int unsigned T_SIDE_G = 6,
    parameter int unsigned T_Y      = 3,
    parameter int unsigned T_AR     = 1,
    parameter int unsigned TW       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [0:2] main_light,
    output logic [0:2] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    // Last timer value of each timed state (state lasts value+1 cycles).
    localparam logic [TW-1:0] MIN_G_LAST  = TW'(T_MIN_G - 1);
    localparam logic [TW-1:0] SIDE_G_LAST = TW'(T_SIDE_G - 1);
    localparam logic [TW-1:0] Y_LAST      = TW'(T_Y - 1);
    localparam logic [TW-1:0] AR_LAST     = TW'(T_AR - 1);

    tj_state_e   state_r;
    tj_state_e   state_next_s;
    logic [TW-1:0] timer_s;
    logic        state_change_s;
    logic        entering_side_s;
    logic        demand_s;
    logic        side_pend_r;
    logic        ped_pend_r;
    logic        walk_arm_r;
    logic        walk_arm_next_s;
    lamp_pair_t  lamps_next_s;
    lamp_pair_t  lamps_r;

    assign state_change_s  = (state_next_s != state_r);
    assign entering_side_s = (state_next_s == SIDE_G) && (state_r != SIDE_G);
    // A request arriving this cycle counts as demand straight away.
    assign demand_s        = side_pend_r | ped_pend_r | side_req | ped_req;

    phase_timer #(
        .TW(TW)
    ) u_phase_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_change_s),
        .count(timer_s)
    );

    // State register; reset parks the junction in the main-bound all-red.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= AR_M;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: timed sequence with demand gating and emergency diversion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MAIN_G: begin
                if (emerg) begin
                    state_next_s = MAIN_Y;
                end else if ((timer_s >= MIN_G_LAST) && demand_s) begin
                    state_next_s = MAIN_Y;
                end else begin
                    state_next_s = MAIN_G;
                end
            end
            MAIN_Y: begin
                if (timer_s >= Y_LAST) begin
                    state_next_s = emerg ? EMERG : AR_S;
                end else begin
                    state_next_s = MAIN_Y;
                end
            end
            AR_S: begin
                if (timer_s >= AR_LAST) begin
                    state_next_s = emerg ? EMERG : SIDE_G;
                end else begin
                    state_next_s = AR_S;
                end
            end
            SIDE_G: begin
                if (emerg) begin
                    state_next_s = SIDE_Y;
                end else if (timer_s >= SIDE_G_LAST) begin
                    state_next_s = SIDE_Y;
                end else begin
                    state_next_s = SIDE_G;
                end
            end
            SIDE_Y: begin
                if (timer_s >= Y_LAST) begin
                    state_next_s = emerg ? EMERG : AR_M;
                end else begin
                    state_next_s = SIDE_Y;
                end
            end
            AR_M: begin
                if (timer_s >= AR_LAST) begin
                    state_next_s = emerg ? EMERG : MAIN_G;
                end else begin
                    state_next_s = AR_M;
                end
            end
            EMERG: begin
                if (emerg) begin
                    state_next_s = EMERG;
                end else begin
                    state_next_s = AR_M;
                end
            end
            default: begin
                state_next_s = AR_M;
            end
        endcase
    end

    // Demand latches: a new request always wins over the clear on side-green entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_pend_r <= 1'b0;
            ped_pend_r  <= 1'b0;
        end else begin
            side_pend_r <= side_req | (side_pend_r & ~entering_side_s);
            ped_pend_r  <= ped_req  | (ped_pend_r  & ~entering_side_s);
        end
    end

    // Walk arm: captured from the pedestrian latch on side-green entry, held through it.
    always_comb begin
        walk_arm_next_s = 1'b0;
        if (state_next_s == SIDE_G) begin
            if (entering_side_s) begin
                walk_arm_next_s = ped_pend_r;
            end else begin
                walk_arm_next_s = walk_arm_r;
            end
        end else begin
            walk_arm_next_s = 1'b0;
        end
    end

    // Walk arm register; it is only ever set while the state is SIDE_G.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_arm_r <= 1'b0;
        end else begin
            walk_arm_r <= walk_arm_next_s;
        end
    end

    // Lamp decode of the state being entered, so registered lamps track state_r.
    always_comb begin
        lamps_next_s = decode_lamps(state_next_s);
    end

    // Lamp registers; reset forces both roads red without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lamps_r.main_lamp <= RED;
            lamps_r.side_lamp <= RED;
        end else begin
            lamps_r <= lamps_next_s;
        end
    end

    assign main_light = lamps_r.main_lamp;
    assign side_light = lamps_r.side_lamp;
    assign walk       = walk_arm_r;
    assign phase      = state_r;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Scenario bench for traffic_junction_ctrl: each scenario pushes its expected
// per-cycle phase/walk sequence into a queue and compares as the DUT advances.
module tb_traffic_junction_ctrl;

    localparam logic [2:0] P_MG = 3'd0;
    localparam logic [2:0] P_MY = 3'd1;
    localparam logic [2:0] P_AS = 3'd2;
    localparam logic [2:0] P_SG = 3'd3;
    localparam logic [2:0] P_SY = 3'd4;
    localparam logic [2:0] P_AM = 3'd5;
    localparam logic [2:0] P_EM = 3'd6;

    localparam logic [0:2] L_RED = 3'b100;
    localparam logic [0:2] L_GRN = 3'b010;
    localparam logic [0:2] L_YEL = 3'b001;

    typedef struct packed {
        logic [2:0] ph;
        logic       w;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       side_req;
    logic       ped_req;
    logic       emerg;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic       walk;
    logic [2:0] phase;

    int   checks;
    int   errors;
    exp_t sb[$];

    traffic_junction_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .emerg     (emerg),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .phase     (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected main-road lamp for a phase code.
    function automatic logic [0:2] exp_main(input logic [2:0] ph);
        case (ph)
            P_MG:    return L_GRN;
            P_MY:    return L_YEL;
            default: return L_RED;
        endcase
    endfunction

    // Expected side-road lamp for a phase code.
    function automatic logic [0:2] exp_side(input logic [2:0] ph);
        case (ph)
            P_SG:    return L_GRN;
            P_SY:    return L_YEL;
            default: return L_RED;
        endcase
    endfunction

    task automatic push_seg(input logic [2:0] ph, input int n, input logic w);
        exp_t e;
        e.ph = ph;
        e.w  = w;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    // Reset, release, and step to the first MAIN_G cycle (timer 0).
    task automatic do_reset();
        side_req = 1'b0;
        ped_req  = 1'b0;
        emerg    = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Never both roads green, checked every cycle.
    always @(negedge clk) begin
        checks++;
        if (main_light == L_GRN && side_light == L_GRN) begin
            errors++;
            $display("FAIL both_green t=%0t: main=%b side=%b, required not both 010", $time, main_light, side_light);
        end
    end

    task automatic test_reset();
        exp_t e;
        int   i;
        rst = 1'b0; side_req = 1'b0; ped_req = 1'b0; emerg = 1'b0;
        #2 rst = 1'b1;
        #1;
        push_seg(P_AM, 2, 1'b0);
        push_seg(P_AM, 1, 1'b0);
        push_seg(P_MG, 50, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL reset idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            if (i == 0) begin
                @(posedge clk); #1;
            end else if (i == 1) begin
                rst = 1'b0;
                #1;
            end else if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
            i++;
        end
    endtask

    task automatic test_side_request();
        exp_t e;
        int   i;
        do_reset();
        push_seg(P_MG, 8, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 6, 1'b0); push_seg(P_SY, 3, 1'b0); push_seg(P_AM, 1, 1'b0);
        push_seg(P_MG, 3, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL side_req idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            side_req = (i == 2);
            i++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        side_req = 1'b0;
    endtask

    task automatic test_ped_late();
        exp_t e;
        int   i;
        do_reset();
        push_seg(P_MG, 21, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 6, 1'b1);  push_seg(P_SY, 3, 1'b0); push_seg(P_AM, 1, 1'b0);
        push_seg(P_MG, 2, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL ped_late idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            ped_req = (i == 20);
            i++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_ped_at_entry();
        exp_t e;
        int   i;
        do_reset();
        push_seg(P_MG, 8, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 6, 1'b0); push_seg(P_SY, 3, 1'b0); push_seg(P_AM, 1, 1'b0);
        push_seg(P_MG, 8, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 6, 1'b1); push_seg(P_SY, 3, 1'b0); push_seg(P_AM, 1, 1'b0);
        push_seg(P_MG, 2, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL ped_entry idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            side_req = (i == 0);
            ped_req  = (i == 12);
            i++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        side_req = 1'b0;
        ped_req  = 1'b0;
    endtask

    task automatic test_emergency();
        exp_t e;
        int   i;
        do_reset();
        push_seg(P_MG, 8, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 4, 1'b0); push_seg(P_SY, 3, 1'b0); push_seg(P_EM, 10, 1'b0);
        push_seg(P_AM, 1, 1'b0); push_seg(P_MG, 2, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL emerg idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            side_req = (i == 0);
            emerg    = (i >= 15 && i < 28);
            i++;
            if (sb.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        side_req = 1'b0;
        emerg    = 1'b0;
    endtask

    task automatic test_reset_mid_side_y();
        exp_t e;
        int   i;
        do_reset();
        push_seg(P_MG, 8, 1'b0); push_seg(P_MY, 3, 1'b0); push_seg(P_AS, 1, 1'b0);
        push_seg(P_SG, 6, 1'b0); push_seg(P_SY, 2, 1'b0);
        push_seg(P_AM, 3, 1'b0); push_seg(P_MG, 2, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (phase !== e.ph || main_light !== exp_main(e.ph) || side_light !== exp_side(e.ph) || walk !== e.w) begin
                errors++;
                $display("FAIL rst_mid idx=%0d: phase=%0d main=%b side=%b walk=%b, required phase=%0d main=%b side=%b walk=%b",
                         i, phase, main_light, side_light, walk, e.ph, exp_main(e.ph), exp_side(e.ph), e.w);
            end
            side_req = (i == 0);
            if (i == 19) begin
                #2 rst = 1'b1;
                #1;
            end else if (i == 20) begin
                @(posedge clk); #1;
            end else if (i == 21) begin
                rst = 1'b0;
                #1;
            end else if (sb.size() > 1) begin
                @(posedge clk); #1;
            end else if (sb.size() == 1) begin
                @(posedge clk); #1;
            end else begin
                #1;
            end
            i++;
        end
        side_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_side_request();
        test_ped_late();
        test_ped_at_entry();
        test_emergency();
        test_reset_mid_side_y();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_junction_ctrl.md
TRAFFIC_JUNCTION_CTRL -- requirements
Module: traffic_junction_ctrl

Interface
REQ-001 Parameters SHALL be: T_MIN_G, default 8, minimum main-green cycles; T_SIDE_G, default 6, side-green cycles; T_Y, default 3, yellow cycles; T_AR, default 1, all-red cycles; TW, default 8, timer width.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 side_req  in  1  side-road vehicle sensor, level or pulse.
REQ-005 ped_req  in  1  pedestrian button, pulse.
REQ-006 emerg  in  1  emergency override, level.
REQ-007 main_light  out  [0:2]  one-hot {red,green,yellow}: red=100, green=010, yellow=001.
REQ-008 side_light  out  [0:2]  same encoding as main_light.
REQ-009 walk  out  1  pedestrian walk lamp.
REQ-010 phase  out  3  current state encoding, for debug and monitoring.

Function
REQ-011 The FSM SHALL have these states: MAIN_G=0, MAIN_Y=1, AR_S=2, SIDE_G=3, SIDE_Y=4, AR_M=5, EMERG=6; code 7 SHALL go to AR_M on the next clock.
REQ-012 The timer SHALL be 0 in the first cycle of every state, increment each cycle, and saturate at 2^TW-1.
REQ-013 Outputs SHALL be Moore-decoded from the state register only, as follows:
- MAIN_G: main green, side red.
- MAIN_Y: main yellow, side red.
- SIDE_G: main red, side green.
- SIDE_Y: main red, side yellow.
- AR_S, AR_M, EMERG: both red.
REQ-014 side_pend and ped_pend SHALL set on any cycle their input is high, and SHALL clear on the cycle the FSM enters SIDE_G.
- A request in that same cycle SHALL still be latched; set wins.
REQ-015 MAIN_G SHALL go to MAIN_Y when timer >= T_MIN_G-1 and (side_pend or ped_pend); with no demand it SHALL hold indefinitely.
REQ-016 MAIN_Y, AR_S, SIDE_G and SIDE_Y SHALL each last exactly T_Y, T_AR, T_SIDE_G and T_Y cycles, in the order MAIN_Y->AR_S->SIDE_G->SIDE_Y->AR_M.
REQ-017 AR_M SHALL last T_AR cycles, then go to MAIN_G.
REQ-018 walk SHALL be high throughout SIDE_G when ped_pend was set on the entry cycle; it SHALL be low in all other states.
- A registered walk_arm flag captured on entry SHALL implement this.
REQ-019 emerg=1 sampled in MAIN_G SHALL go to MAIN_Y, and in SIDE_G to SIDE_Y, on the next clock.
REQ-020 While emerg=1, a yellow or all-red state SHALL finish its normal duration and then go to EMERG instead of its normal successor.
REQ-021 EMERG SHALL hold while emerg=1; on emerg=0 it SHALL go to AR_M.
- Pending requests SHALL be retained across EMERG.
REQ-022 Green SHALL never be shown on both roads at once, and a green-to-green change SHALL always pass through yellow and all-red of at least T_AR cycles.

Reset
REQ-023 While rst=1, and asynchronously on its assertion, the block SHALL be in this reset state:
- state=AR_M, timer=0;
- side_pend=0, ped_pend=0, walk_arm=0;
- main_light=100, side_light=100, walk=0, phase=5.
REQ-024 On rst deassertion the first clock SHALL advance the timer in AR_M; MAIN_G SHALL be entered T_AR cycles later.
REQ-025 Reset asserted mid-cycle in any state SHALL drive both roads red immediately, without waiting for a clock.

Structure
REQ-026 State encodings and light codes (RED, GREEN, YELLOW) SHALL live in a shared package traffic_pkg, for reuse by the cyclic lamp and this block.
REQ-027 The block SHALL contain one sub-module, phase_timer: a TW-bit counter with a clear-on-state-change input and saturating increment.

Verification
REQ-028 The bench SHALL cover, with default parameters:
- Reset then release, no requests -> phase 5 for 1 cycle, then MAIN_G held 50 cycles with side_light=100.
- side_req pulse at MAIN_G cycle 2 -> main green 8 cycles, yellow 3, AR_S 1, SIDE_G 6, SIDE_Y 3, AR_M 1, then MAIN_G; walk stays 0.
- ped_req pulse at MAIN_G cycle 20 -> MAIN_Y on next cycle; walk=1 for exactly the 6 SIDE_G cycles.
- ped_req in the SIDE_G entry cycle -> no walk this round; next cycle sequence starts after main green reaches 8 cycles, with walk=1.
- emerg raised at SIDE_G cycle 3 -> SIDE_Y 3 cycles, then EMERG held; emerg drop -> AR_M 1 cycle, then MAIN_G.
- rst asserted mid-SIDE_Y -> both lights 100 before the next clock edge; assertion at every cycle checks both roads are never green together.
